// File: rtl/safe_hart_sync_responder_if.sv
// Purpose: controller- and core-facing signals of one hart's safe-mode halt/sync responder.
// Latency: wiring only.
// Backpressure: none; every signal is a level.
interface safe_hart_sync_responder_if;
   // controller -> responder
   logic safe_mode_i;
   logic master_core_i;
   logic interrupt_halt_i;
   logic interrupt_sync_i;
   // core -> responder
   logic core_halted_i;
   logic core_wfi_i;
   logic core_irq_ack_i;
   // responder -> core
   logic core_halt_req_o;
   logic core_irq_o;
   // responder -> controller
   logic halt_ack_o;
   logic hart_wfi_o;
   logic hart_intc_ack_o;
   logic timeout_err_o;

   // the responder itself
   modport slave (
      input  safe_mode_i, master_core_i, interrupt_halt_i, interrupt_sync_i,
      input  core_halted_i, core_wfi_i, core_irq_ack_i,
      output core_halt_req_o, core_irq_o,
      output halt_ack_o, hart_wfi_o, hart_intc_ack_o, timeout_err_o
   );

   // whoever drives the responder (controller plus core, or a bench)
   modport master (
      output safe_mode_i, master_core_i, interrupt_halt_i, interrupt_sync_i,
      output core_halted_i, core_wfi_i, core_irq_ack_i,
      input  core_halt_req_o, core_irq_o,
      input  halt_ack_o, hart_wfi_o, hart_intc_ack_o, timeout_err_o
   );
endinterface

// File: rtl/safe_hart_sync_responder.sv
// Purpose: hart-side agent of the safe-mode halt/sync handshake; drives core halt/irq, reports acks, wfi and timeout.
// Latency: every output is registered and changes on the edge at which the state (or the wfi filter) changes.
// Backpressure: none; level handshakes, HALT_REQ/SYNC_IRQ give up after TIMEOUT_CYCLES into a sticky ERROR.
module safe_hart_sync_responder #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int WFI_STABLE     = 2
) (
   input logic                        clk_i,
   input logic                        rst_i,
   safe_hart_sync_responder_if.slave  bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int WW = $clog2(WFI_STABLE + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
   localparam logic [WW-1:0] WFI_MAX  = WW'(WFI_STABLE);

   typedef enum logic [2:0] {
      IDLE,
      HALT_REQ,
      HALTED,
      WAIT_SYNC,
      SYNC_IRQ,
      SYNC_ACK,
      ERROR
   } state_e;

   state_e         state_q, state_d;
   logic [TW-1:0]  tmo_cnt_q;
   logic [WW-1:0]  wfi_cnt_q;
   logic           tmo_hit;

   // The counter reaches TMO_LAST in the final allowed cycle of a timed state.
   assign tmo_hit = (tmo_cnt_q == TMO_LAST);

   // Next-state decode; exit conditions are checked before the timeout so they win in the last cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.interrupt_halt_i && bus.safe_mode_i && !bus.master_core_i) state_d = HALT_REQ;
            else if (bus.interrupt_sync_i)                                     state_d = SYNC_IRQ;
         end
         HALT_REQ: begin
            if (bus.core_halted_i)     state_d = HALTED;
            else if (!bus.safe_mode_i) state_d = IDLE;
            else if (tmo_hit)          state_d = ERROR;
         end
         HALTED: begin
            if (!bus.core_halted_i) state_d = WAIT_SYNC;
         end
         WAIT_SYNC: begin
            if (bus.interrupt_sync_i)  state_d = SYNC_IRQ;
            else if (!bus.safe_mode_i) state_d = IDLE;
         end
         SYNC_IRQ: begin
            if (bus.core_irq_ack_i) state_d = SYNC_ACK;
            else if (tmo_hit)       state_d = ERROR;
         end
         SYNC_ACK: begin
            if (!bus.interrupt_sync_i) state_d = IDLE;
         end
         ERROR: begin
            if (!bus.safe_mode_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, timeout counter and FSM outputs; outputs are decoded from the next state so they land with it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q             <= IDLE;
         tmo_cnt_q           <= '0;
         bus.core_halt_req_o <= 1'b0;
         bus.halt_ack_o      <= 1'b0;
         bus.core_irq_o      <= 1'b0;
         bus.hart_intc_ack_o <= 1'b0;
         bus.timeout_err_o   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            tmo_cnt_q <= '0;
         else if ((state_q == HALT_REQ || state_q == SYNC_IRQ) && tmo_cnt_q != TMO_MAX)
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         bus.core_halt_req_o <= (state_d == HALT_REQ);
         bus.halt_ack_o      <= (state_d == HALTED);
         bus.core_irq_o      <= (state_d == SYNC_IRQ);
         bus.hart_intc_ack_o <= (state_d == SYNC_ACK);
         bus.timeout_err_o   <= (state_d == ERROR);
      end
   end

   // WFI glitch filter, independent of the FSM: asserts once wfi has been seen WFI_STABLE edges in a row.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wfi_cnt_q      <= '0;
         bus.hart_wfi_o <= 1'b0;
      end else begin
         if (!bus.core_wfi_i)        wfi_cnt_q <= '0;
         else if (wfi_cnt_q != WFI_MAX) wfi_cnt_q <= wfi_cnt_q + 1'b1;
         bus.hart_wfi_o <= bus.core_wfi_i && (wfi_cnt_q == WFI_MAX);
      end
   end

endmodule

// File: tb/tb_safe_hart_sync_responder.sv
// Directed bench for safe_hart_sync_responder with TIMEOUT_CYCLES=16, WFI_STABLE=2.
// Each step pushes the expected output vector, advances one edge, pops and compares.
// Output vector order: {core_halt_req, halt_ack, core_irq, hart_intc_ack, hart_wfi, timeout_err}.
module tb_safe_hart_sync_responder;

   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] REQ  = 6'b100000;
   localparam logic [5:0] ACK  = 6'b010000;
   localparam logic [5:0] IRQ  = 6'b001000;
   localparam logic [5:0] IAK  = 6'b000100;
   localparam logic [5:0] WFI  = 6'b000010;
   localparam logic [5:0] ERR  = 6'b000001;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      string      tag;
      logic [5:0] exp;
   } exp_t;

   exp_t sb[$];

   safe_hart_sync_responder_if bus();

   safe_hart_sync_responder #(
      .TIMEOUT_CYCLES (16),
      .WFI_STABLE     (2)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   wire [5:0] obs_v = {bus.core_halt_req_o, bus.halt_ack_o, bus.core_irq_o,
                       bus.hart_intc_ack_o, bus.hart_wfi_o, bus.timeout_err_o};

   initial forever #5 clk_i = ~clk_i;

   task automatic tick(input string tag, input logic [5:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
      @(posedge clk_i);
      #1;
      e = sb.pop_front();
      checks++;
      assert (obs_v === e.exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", e.tag, obs_v, e.exp);
      end
   endtask

   initial begin
      bus.safe_mode_i      = 1'b0;
      bus.master_core_i    = 1'b0;
      bus.interrupt_halt_i = 1'b0;
      bus.interrupt_sync_i = 1'b0;
      bus.core_halted_i    = 1'b0;
      bus.core_wfi_i       = 1'b0;
      bus.core_irq_ack_i   = 1'b0;

      // reset
      rst_i = 1'b1;
      tick("reset0", NONE);
      tick("reset1", NONE);
      rst_i = 1'b0;
      tick("idle", NONE);

      // non-master halt handshake
      bus.safe_mode_i      = 1'b1;
      bus.interrupt_halt_i = 1'b1;
      tick("halt_c1", REQ);
      bus.interrupt_halt_i = 1'b0;
      tick("halt_c2", REQ);
      tick("halt_c3", REQ);
      bus.core_halted_i = 1'b1;
      tick("halt_ack_c4", ACK);
      tick("halt_ack_hold", ACK);
      bus.core_halted_i = 1'b0;
      tick("wait_sync", NONE);
      tick("wait_sync_hold", NONE);

      // sync interrupt from WAIT_SYNC
      bus.interrupt_sync_i = 1'b1;
      tick("sync_irq", IRQ);
      for (int i = 0; i < 4; i++) tick($sformatf("sync_irq_hold%0d", i), IRQ);
      bus.core_irq_ack_i = 1'b1;
      tick("sync_ack", IAK);
      bus.core_irq_ack_i = 1'b0;
      tick("sync_ack_hold", IAK);
      bus.interrupt_sync_i = 1'b0;
      tick("sync_done", NONE);
      bus.safe_mode_i = 1'b0;
      tick("sync_idle", NONE);

      // halt timeout: 16 cycles in HALT_REQ then sticky error
      bus.safe_mode_i      = 1'b1;
      bus.interrupt_halt_i = 1'b1;
      tick("tmo_c1", REQ);
      bus.interrupt_halt_i = 1'b0;
      for (int i = 2; i <= 16; i++) tick($sformatf("tmo_c%0d", i), REQ);
      tick("tmo_c17", ERR);
      for (int i = 0; i < 3; i++) tick($sformatf("tmo_sticky%0d", i), ERR);
      bus.safe_mode_i = 1'b0;
      tick("tmo_clear", NONE);

      // halted arriving in the final cycle beats the timeout
      bus.safe_mode_i      = 1'b1;
      bus.interrupt_halt_i = 1'b1;
      tick("edge_c1", REQ);
      bus.interrupt_halt_i = 1'b0;
      for (int i = 2; i <= 16; i++) tick($sformatf("edge_c%0d", i), REQ);
      bus.core_halted_i = 1'b1;
      tick("edge_c17_ack", ACK);
      bus.core_halted_i = 1'b0;
      tick("edge_wait_sync", NONE);
      bus.safe_mode_i = 1'b0;
      tick("edge_idle", NONE);

      // master never halts; halt beats simultaneous sync for a non-master
      bus.safe_mode_i      = 1'b1;
      bus.master_core_i    = 1'b1;
      bus.interrupt_halt_i = 1'b1;
      tick("master_no_halt0", NONE);
      tick("master_no_halt1", NONE);
      bus.master_core_i    = 1'b0;
      bus.interrupt_sync_i = 1'b1;
      tick("halt_beats_sync", REQ);
      bus.interrupt_halt_i = 1'b0;
      bus.interrupt_sync_i = 1'b0;
      bus.safe_mode_i      = 1'b0;
      tick("halt_abort", NONE);

      // wfi filter
      bus.core_wfi_i = 1'b1;
      tick("wfi_short", NONE);
      bus.core_wfi_i = 1'b0;
      tick("wfi_short_low", NONE);
      bus.core_wfi_i = 1'b1;
      tick("wfi_e1", NONE);
      tick("wfi_e2", NONE);
      tick("wfi_e3", WFI);
      bus.core_wfi_i = 1'b0;
      tick("wfi_fall", NONE);

      // sync path ignores safe_mode; reset mid-op then a fresh halt
      bus.interrupt_sync_i = 1'b1;
      tick("rst_sync_irq", IRQ);
      tick("rst_sync_no_safe", IRQ);
      bus.core_wfi_i = 1'b1;
      rst_i = 1'b1;
      tick("rst_mid_op", NONE);
      rst_i = 1'b0;
      bus.core_wfi_i       = 1'b0;
      bus.interrupt_sync_i = 1'b0;
      tick("rst_idle", NONE);
      bus.safe_mode_i      = 1'b1;
      bus.interrupt_halt_i = 1'b1;
      tick("post_rst_req", REQ);
      bus.interrupt_halt_i = 1'b0;
      bus.core_halted_i    = 1'b1;
      tick("post_rst_ack", ACK);
      bus.core_halted_i = 1'b0;
      tick("post_rst_wait", NONE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
